// File: rtl/mult_seq_rom_ram.sv
// Sequential shift-add multiplier: two operands come from a fixed ROM, and the product goes into a RAM.
// Define SIGNED_MODE_EN to treat the operands as two's complement. The default build is unsigned.
module mult_seq_rom_ram #(
    parameter int WIDTH = 4,
    parameter int AW    = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [AW-1:0]        i_adr1,
    input  logic [AW-1:0]        i_adr2,
    input  logic [AW-1:0]        i_adr_ram,
    input  logic [AW-1:0]        i_rd_adr,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_st_out
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MULT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state, w_next;
    logic [AW-1:0]        r_adr1, r_adr2, r_adr_ram;
    logic [PW-1:0]        r_a, r_acc, r_result;
    logic [WIDTH-1:0]     r_b;
    logic [CW-1:0]        r_cnt;
    logic [PW-1:0]        r_ram [2**AW] = '{default: '0};

    logic [WIDTH-1:0]     w_rom1, w_rom2;
    logic [PW-1:0]        w_a_ext;
    logic                 w_last, w_sub;

    function automatic logic [WIDTH-1:0] rom_rd(input logic [AW-1:0] a);
        logic [AW+WIDTH:0] t;
        t = (AW+WIDTH+1)'(a) + (AW+WIDTH+1)'(1);
        return t[WIDTH-1:0];
    endfunction

    assign w_rom1 = rom_rd(r_adr1);
    assign w_rom2 = rom_rd(r_adr2);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef SIGNED_MODE_EN
    // The final iteration weighs the multiplier's sign bit by -2^(WIDTH-1).
    assign w_a_ext = {{WIDTH{w_rom1[WIDTH-1]}}, w_rom1};
    assign w_sub   = w_last;
`else
    assign w_a_ext = {{WIDTH{1'b0}}, w_rom1};
    assign w_sub   = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_MULT;
            S_MULT:  w_next = w_last ? S_WRITE : S_MULT;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_adr1    <= '0;
            r_adr2    <= '0;
            r_adr_ram <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_adr1    <= i_adr1;
                    r_adr2    <= i_adr2;
                    r_adr_ram <= i_adr_ram;
                end
                S_LOAD: begin
                    r_a   <= w_a_ext;
                    r_b   <= w_rom2;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                S_MULT: begin
                    if (r_b[0]) r_acc <= w_sub ? (r_acc - r_a) : (r_acc + r_a);
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // The RAM has no reset. Contents survive reset, and an aborted operation never reaches WRITE.
    always_ff @(posedge i_clk) begin
        if (r_state == S_WRITE) r_ram[r_adr_ram] <= r_acc;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_result <= '0;
        else        r_result <= r_ram[i_rd_adr];
    end

    assign o_result = r_result;
    assign o_st_out = r_state;
    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = (r_state == S_DONE);
endmodule

// File: tb/tb_mult_seq_rom_ram.sv
// Self-checking bench for mult_seq_rom_ram: vector table, corner sequences and random ops vs. an arithmetic model.
module tb_mult_seq_rom_ram;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] adr1 = '0, adr2 = '0, adr_ram = '0, rd_adr = '0;
    logic [7:0] result;
    logic       busy, done;
    logic [2:0] st;

    int errs = 0;
    int checks = 0;
    logic [7:0] ram_m [8];

    mult_seq_rom_ram #(.WIDTH(4), .AW(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_adr1(adr1), .i_adr2(adr2), .i_adr_ram(adr_ram), .i_rd_adr(rd_adr),
        .o_result(result), .o_busy(busy), .o_done(done), .o_st_out(st)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         a1;
        int         a2;
        int         ar;
        logic [7:0] exp;
    } vec_t;

    function automatic int romv(input int i);
        return (i + 1) % 16;
    endfunction

    function automatic logic [7:0] prod(input int x, input int y);
        int sx, sy, p;
        sx = x;
        sy = y;
`ifdef SIGNED_MODE_EN
        if (sx >= 8) sx -= 16;
        if (sy >= 8) sy -= 16;
`endif
        p = sx * sy;
        return p[7:0];
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic rd(input int a, output logic [7:0] v);
        @(negedge clk);
        rd_adr = 3'(a);
        @(negedge clk);
        v = result;
        chk("readback", 32'(result), 32'(ram_m[a]));
    endtask

    // One full operation. A second start can be pulsed while the block is busy (restart=1).
    task automatic do_op(input int a1, input int a2, input int ar, input bit restart);
        logic [7:0] old, p;
        int seq[8] = '{1, 2, 2, 2, 2, 3, 4, 0};
        old = ram_m[ar];
        p   = prod(romv(a1), romv(a2));
        @(negedge clk);
        adr1 = 3'(a1); adr2 = 3'(a2); adr_ram = 3'(ar); rd_adr = 3'(ar); start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                adr1 = 3'($urandom); adr2 = 3'($urandom); adr_ram = 3'(ar + 1);
            end
            if (restart && k == 2) begin
                start = 1'b1; adr1 = 3'd0; adr2 = 3'd0; adr_ram = 3'(ar ^ 4);
            end
            if (restart && k == 3) start = 1'b0;
            chk("st_out", 32'(st), 32'(seq[k]));
            chk("busy", 32'(busy), 32'(k < 7));
            chk("done", 32'(done), 32'(k == 6));
            if (k == 6) chk("rbw_old", 32'(result), 32'(old));
            if (k == 7) chk("rbw_new", 32'(result), 32'(p));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("idle_after", 32'(st), 32'd0);
        end
        ram_m[ar] = p;
    endtask

    task automatic abort_op(input int a1, input int a2, input int ar);
        logic [7:0] v;
        @(negedge clk);
        adr1 = 3'(a1); adr2 = 3'(a2); adr_ram = 3'(ar); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_st", 32'(st), 32'd2);
        rst = 1'b0;
        #1;
        chk("abort_st", 32'(st), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int k = 0; k < 8; k++) @(negedge clk);
        rst = 1'b1;
        rd(ar, v);
    endtask

    initial begin
        vec_t tv[6];
        logic [7:0] v;
        for (int i = 0; i < 8; i++) ram_m[i] = 8'h00;
`ifdef SIGNED_MODE_EN
        tv[0] = '{1, 2, 0, 8'h06};
        tv[1] = '{7, 2, 5, 8'hE8};
        tv[2] = '{7, 7, 3, 8'h40};
        tv[3] = '{3, 6, 2, 8'h1C};
        tv[4] = '{4, 5, 6, 8'h1E};
        tv[5] = '{6, 7, 1, 8'hC8};
`else
        tv[0] = '{1, 2, 0, 8'h06};
        tv[1] = '{7, 2, 5, 8'h18};
        tv[2] = '{7, 7, 3, 8'h40};
        tv[3] = '{3, 6, 2, 8'h1C};
        tv[4] = '{4, 5, 6, 8'h1E};
        tv[5] = '{6, 7, 1, 8'h38};
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_st", 32'(st), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(tv[i].a1, tv[i].a2, tv[i].ar, 1'b0);
            rd(tv[i].ar, v);
            chk("table", 32'(v), 32'(tv[i].exp));
        end

        // A start pulsed while busy is ignored. Address 4^4 = 0 must keep 06.
        do_op(2, 3, 4, 1'b1);
        rd(0, v);
        chk("restart_ignored", 32'(v), 32'h06);

        for (int i = 0; i < 12; i++)
            do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0);

        // The abort leaves entry 5 untouched. A following op then completes normally.
        abort_op(0, 0, 5);
        do_op(0, 0, 5, 1'b0);
        rd(5, v);
        chk("post_abort", 32'(v), 32'h01);

        for (int i = 0; i < 8; i++) rd(i, v);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
